// File: rtl/pulse_gen_mc_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// pulse_gen_mc_pkg : shared state encodings for the pulse generator channels
// Rev 1.0
// ----------------------------------------------------------------------------
package pulse_gen_mc_pkg;

  typedef logic [3:0] state_t;

  localparam state_t ST_IDLE  = 4'b0001;
  localparam state_t ST_DELAY = 4'b0010;
  localparam state_t ST_PULSE = 4'b0100;
  localparam state_t ST_GAP   = 4'b1000;

endpackage
`default_nettype wire

// File: rtl/pulse_chan.sv
`default_nettype none
// ----------------------------------------------------------------------------
// pulse_chan : one generator channel - trigger edge detect, sequencing FSM,
//              delay/width/gap down-counter and registered outputs
// Rev 1.0
// ----------------------------------------------------------------------------
module pulse_chan
  import pulse_gen_mc_pkg::*;
#(
  parameter int CW = 8,
  parameter int RW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start_i,
  input  logic          mode_i,
  input  logic [CW-1:0] dly_i,
  input  logic [CW-1:0] wid_i,
  input  logic [CW-1:0] gap_i,
  input  logic [RW-1:0] rep_i,
  output logic          y_o,
  output logic          busy_o,
  output logic          done_o
);

  logic          s1_q, s2_q;
  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] wid_q, wid_d;
  logic [CW-1:0] gap_q, gap_d;
  logic [RW-1:0] pcnt_q, pcnt_d;
  logic [RW-1:0] rep_q, rep_d;
  logic          y_q, busy_q, done_q, done_d;
  logic          trig, accept;

  assign trig   = s1_q & ~s2_q;
  // A zero-width request is dropped; mode only matters once a sequence runs.
  assign accept = trig && (wid_i != '0) && ((state_q == ST_IDLE) || mode_i);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wid_d   = wid_q;
    gap_d   = gap_q;
    pcnt_d  = pcnt_q;
    rep_d   = rep_q;
    done_d  = 1'b0;
    if (accept) begin
      wid_d  = wid_i;
      gap_d  = gap_i;
      rep_d  = (rep_i == '0) ? RW'(1) : rep_i;
      pcnt_d = '0;
      if (dly_i == '0) begin
        state_d = ST_PULSE;
        cnt_d   = wid_i;
      end else begin
        state_d = ST_DELAY;
        cnt_d   = dly_i;
      end
    end else begin
      case (state_q)
        ST_DELAY: begin
          if (cnt_q == CW'(1)) begin
            state_d = ST_PULSE;
            cnt_d   = wid_q;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        ST_PULSE: begin
          if (cnt_q != CW'(1)) begin
            cnt_d = cnt_q - 1'b1;
          end else if (pcnt_q + 1'b1 == rep_q) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            pcnt_d  = '0;
            done_d  = 1'b1;
          end else begin
            pcnt_d = pcnt_q + 1'b1;
            if (gap_q == '0) begin
              cnt_d = wid_q;
            end else begin
              state_d = ST_GAP;
              cnt_d   = gap_q;
            end
          end
        end
        ST_GAP: begin
          if (cnt_q == CW'(1)) begin
            state_d = ST_PULSE;
            cnt_d   = wid_q;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs are registered from the next state so they change with the FSM.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      wid_q   <= '0;
      gap_q   <= '0;
      pcnt_q  <= '0;
      rep_q   <= '0;
      y_q     <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      s1_q    <= start_i;
      s2_q    <= s1_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wid_q   <= wid_d;
      gap_q   <= gap_d;
      pcnt_q  <= pcnt_d;
      rep_q   <= rep_d;
      y_q     <= (state_d == ST_PULSE);
      busy_q  <= (state_d != ST_IDLE);
      done_q  <= done_d;
    end
  end

  assign y_o    = y_q;
  assign busy_o = busy_q;
  assign done_o = done_q;

endmodule
`default_nettype wire

// File: rtl/pulse_gen_mc.sv
`default_nettype none
// ----------------------------------------------------------------------------
// pulse_gen_mc : CH independent programmable burst pulse generators
// Rev 1.0
// ----------------------------------------------------------------------------
module pulse_gen_mc #(
  parameter int CH = 4,
  parameter int CW = 8,
  parameter int RW = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [CH-1:0]    start_i,
  input  logic [CH-1:0]    mode_i,
  input  logic [CH*CW-1:0] dly_i,
  input  logic [CH*CW-1:0] wid_i,
  input  logic [CH*CW-1:0] gap_i,
  input  logic [CH*RW-1:0] rep_i,
  output logic [CH-1:0]    y_o,
  output logic [CH-1:0]    busy_o,
  output logic [CH-1:0]    done_o
);

  for (genvar i = 0; i < CH; i++) begin : g_chan
    pulse_chan #(
      .CW (CW),
      .RW (RW)
    ) u_chan (
      .clk     (clk),
      .rst_n   (rst_n),
      .start_i (start_i[i]),
      .mode_i  (mode_i[i]),
      .dly_i   (dly_i[i*CW +: CW]),
      .wid_i   (wid_i[i*CW +: CW]),
      .gap_i   (gap_i[i*CW +: CW]),
      .rep_i   (rep_i[i*RW +: RW]),
      .y_o     (y_o[i]),
      .busy_o  (busy_o[i]),
      .done_o  (done_o[i])
    );
  end

endmodule
`default_nettype wire

// File: tb/tb_pulse_gen_mc.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_pulse_gen_mc : directed self-checking bench for pulse_gen_mc
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_pulse_gen_mc;

  localparam int CH = 4;
  localparam int CW = 8;
  localparam int RW = 4;

  logic             clk   = 1'b0;
  logic             rst_n = 1'b0;
  logic [CH-1:0]    start = '0;
  logic [CH-1:0]    mode  = '0;
  logic [CH*CW-1:0] dly   = '0;
  logic [CH*CW-1:0] wid   = '0;
  logic [CH*CW-1:0] gap   = '0;
  logic [CH*RW-1:0] rep   = '0;
  logic [CH-1:0]    y_o, busy_o, done_o;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pulse_gen_mc #(.CH(CH), .CW(CW), .RW(RW)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start_i (start),
    .mode_i  (mode),
    .dly_i   (dly),
    .wid_i   (wid),
    .gap_i   (gap),
    .rep_i   (rep),
    .y_o     (y_o),
    .busy_o  (busy_o),
    .done_o  (done_o)
  );

  // Reference timing: j counts edges after the edge that first samples start high.
  function automatic int rn(int r);
    return (r == 0) ? 1 : r;
  endfunction

  function automatic logic [2:0] m_ch(int j, int d, int w, int g, int r);
    logic yv;
    int   e;
    if (w == 0) return 3'b000;
    e  = 1 + d + rn(r) * w + (rn(r) - 1) * g;
    yv = 1'b0;
    for (int p = 0; p < rn(r); p++)
      if (j >= 1 + d + p * (w + g) && j < 1 + d + p * (w + g) + w) yv = 1'b1;
    return {yv, (j >= 1 && j < e), (j == e)};
  endfunction

  function automatic logic [3*CH-1:0] pack(int ch, logic [2:0] m);
    logic [CH-1:0] a, b, c;
    a = '0; b = '0; c = '0;
    a[ch] = m[2]; b[ch] = m[1]; c[ch] = m[0];
    return {a, b, c};
  endfunction

  task automatic set_cfg(input int ch, input int d, input int w, input int g,
                         input int r, input logic m);
    dly[ch*CW +: CW] = CW'(d);
    wid[ch*CW +: CW] = CW'(w);
    gap[ch*CW +: CW] = CW'(g);
    rep[ch*RW +: RW] = RW'(r);
    mode[ch]         = m;
  endtask

  task automatic quiet();
    start = '0;
    mode  = '0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      total++;
      if ({y_o, busy_o, done_o} !== '0) begin
        bad++;
        $display("FAIL reset_hold j=%0d got=%b exp=0", j, {y_o, busy_o, done_o});
      end
    end
    rst_n = 1'b1;
    for (int j = 0; j < 2; j++) begin
      @(negedge clk);
      total++;
      if ({y_o, busy_o, done_o} !== '0) begin
        bad++;
        $display("FAIL reset_release j=%0d got=%b exp=0", j, {y_o, busy_o, done_o});
      end
    end
  endtask

  task automatic test_basic();
    logic [3*CH-1:0] e;
    set_cfg(0, 3, 5, 2, 1, 1'b0);
    start[0] = 1'b1;
    for (int j = 0; j < 13; j++) begin
      @(negedge clk);
      e = pack(0, m_ch(j, 3, 5, 2, 1));
      total++;
      if ({y_o, busy_o, done_o} !== e) begin
        bad++;
        $display("FAIL basic j=%0d got=%b exp=%b", j, {y_o, busy_o, done_o}, e);
      end
    end
    quiet();
  endtask

  task automatic test_burst();
    logic [13:0]     pat;
    logic [2:0]      m;
    logic [3*CH-1:0] e;
    pat = 14'b11000110001100;
    set_cfg(1, 0, 2, 3, 3, 1'b0);
    start[1] = 1'b1;
    for (int j = 0; j < 17; j++) begin
      @(negedge clk);
      m    = m_ch(j, 0, 2, 3, 3);
      m[2] = (j >= 1 && j <= 14) ? pat[14-j] : 1'b0;
      e    = pack(1, m);
      total++;
      if ({y_o, busy_o, done_o} !== e) begin
        bad++;
        $display("FAIL burst j=%0d got=%b exp=%b", j, {y_o, busy_o, done_o}, e);
      end
    end
    quiet();
  endtask

  task automatic test_retrigger(input logic md);
    logic [2:0]      m;
    logic [3*CH-1:0] e;
    set_cfg(2, 4, 10, 0, 1, md);
    start[2] = 1'b1;
    for (int j = 0; j < 29; j++) begin
      @(negedge clk);
      if (md)
        m = {(j >= 5 && j <= 10) || (j >= 15 && j <= 24), (j >= 1 && j <= 24), (j == 25)};
      else
        m = {(j >= 5 && j <= 14), (j >= 1 && j <= 14), (j == 15)};
      e = pack(2, m);
      total++;
      if ({y_o, busy_o, done_o} !== e) begin
        bad++;
        $display("FAIL retrigger_m%0d j=%0d got=%b exp=%b", md, j, {y_o, busy_o, done_o}, e);
      end
      if (j == 8) start[2] = 1'b0;
      if (j == 9) start[2] = 1'b1;
    end
    quiet();
  endtask

  task automatic test_boundaries();
    logic [3*CH-1:0] e;
    // zero width: trigger dropped
    set_cfg(3, 2, 0, 1, 1, 1'b0);
    start[3] = 1'b1;
    for (int j = 0; j < 8; j++) begin
      @(negedge clk);
      total++;
      if ({y_o, busy_o, done_o} !== '0) begin
        bad++;
        $display("FAIL wid0 j=%0d got=%b exp=0", j, {y_o, busy_o, done_o});
      end
    end
    quiet();
    // rep=0 behaves as a single pulse
    set_cfg(3, 1, 3, 2, 0, 1'b0);
    start[3] = 1'b1;
    for (int j = 0; j < 9; j++) begin
      @(negedge clk);
      e = pack(3, {(j >= 2 && j <= 4), (j >= 1 && j <= 4), (j == 5)});
      total++;
      if ({y_o, busy_o, done_o} !== e) begin
        bad++;
        $display("FAIL rep0 j=%0d got=%b exp=%b", j, {y_o, busy_o, done_o}, e);
      end
    end
    quiet();
    // maximum delay and width
    set_cfg(0, 255, 255, 0, 1, 1'b0);
    start[0] = 1'b1;
    for (int j = 0; j < 515; j++) begin
      @(negedge clk);
      e = pack(0, {(j >= 256 && j <= 510), (j >= 1 && j <= 510), (j == 511)});
      total++;
      if ({y_o, busy_o, done_o} !== e) begin
        bad++;
        $display("FAIL max255 j=%0d got=%b exp=%b", j, {y_o, busy_o, done_o}, e);
      end
    end
    quiet();
    // new trigger landing in the done cycle
    set_cfg(1, 0, 2, 0, 1, 1'b0);
    start[1] = 1'b1;
    for (int j = 0; j < 10; j++) begin
      @(negedge clk);
      e = pack(1, {(j == 1 || j == 2 || j == 4 || j == 5),
                   (j == 1 || j == 2 || j == 4 || j == 5), (j == 3 || j == 6)});
      total++;
      if ({y_o, busy_o, done_o} !== e) begin
        bad++;
        $display("FAIL done_cycle_trig j=%0d got=%b exp=%b", j, {y_o, busy_o, done_o}, e);
      end
      if (j == 1) start[1] = 1'b0;
      if (j == 2) start[1] = 1'b1;
    end
    quiet();
  endtask

  task automatic test_reset_mid();
    logic [3*CH-1:0] e;
    set_cfg(0, 1, 10, 0, 1, 1'b0);
    start[0] = 1'b1;
    for (int j = 0; j < 24; j++) begin
      @(negedge clk);
      if (j < 5)       e = pack(0, m_ch(j, 1, 10, 0, 1));
      else if (j == 5) e = '0;
      else             e = pack(0, m_ch(j - 6, 1, 10, 0, 1));
      total++;
      if ({y_o, busy_o, done_o} !== e) begin
        bad++;
        $display("FAIL reset_mid j=%0d got=%b exp=%b", j, {y_o, busy_o, done_o}, e);
      end
      if (j == 4) rst_n = 1'b0;
      if (j == 5) rst_n = 1'b1;
    end
    quiet();
  endtask

  task automatic test_independence();
    logic [3*CH-1:0] e;
    set_cfg(0, 2, 3, 1, 2, 1'b0);
    set_cfg(1, 0, 1, 0, 4, 1'b0);
    set_cfg(2, 5, 2, 2, 2, 1'b0);
    set_cfg(3, 1, 4, 0, 0, 1'b0);
    start = '1;
    for (int j = 0; j < 18; j++) begin
      @(negedge clk);
      e = pack(0, m_ch(j, 2, 3, 1, 2)) | pack(1, m_ch(j, 0, 1, 0, 4)) |
          pack(2, m_ch(j, 5, 2, 2, 2)) | pack(3, m_ch(j, 1, 4, 0, 0));
      total++;
      if ({y_o, busy_o, done_o} !== e) begin
        bad++;
        $display("FAIL independence j=%0d got=%b exp=%b", j, {y_o, busy_o, done_o}, e);
      end
      if (j == 3)
        for (int c = 0; c < CH; c++) set_cfg(c, 1, 7, 1, 2, 1'b0);
    end
    quiet();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_burst();
    test_retrigger(1'b1);
    test_retrigger(1'b0);
    test_boundaries();
    test_reset_mid();
    test_independence();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
